// File: rtl/mult_pkg.sv
// Op codes, sequencer state encodings and op-decode helpers shared by the HI/LO multiply controller.
package mult_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MADD  = 3'd2;
  localparam logic [2:0] OP_MADDU = 3'd3;
  localparam logic [2:0] OP_MSUB  = 3'd4;
  localparam logic [2:0] OP_MSUBU = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;

  localparam logic [1:0] ACC_PASS = 2'd0;
  localparam logic [1:0] ACC_ADD  = 2'd1;
  localparam logic [1:0] ACC_SUB  = 2'd2;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic [1:0] op_acc_mode(input logic [2:0] op);
    case (op)
      OP_MADD, OP_MADDU: return ACC_ADD;
      OP_MSUB, OP_MSUBU: return ACC_SUB;
      default:           return ACC_PASS;
    endcase
  endfunction

endpackage

// File: rtl/hilo_accum.sv
// Combinational HI/LO update: pass, add or subtract the 64-bit product (modulo 2^64).
// Only present when MULT_MADDSUB_EN is defined.
`ifdef MULT_MADDSUB_EN
module hilo_accum
  import mult_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [63:0] hilo,
  input  logic [63:0] prod,
  output logic [63:0] result
);

  always_comb begin
    result = prod;
    case (mode)
      ACC_ADD: result = hilo + prod;
      ACC_SUB: result = hilo - prod;
      default: result = prod;
    endcase
  end

endmodule
`endif

// File: rtl/mult_hilo_ctrl.sv
// Multiply sequencer and HI/LO register pair behind the DSP48A1 multiplier array.
// Define MULT_MADDSUB_EN to enable MADD/MADDU/MSUB/MSUBU accumulation; otherwise they are no-ops.
module mult_hilo_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned MULT_LATENCY = 4
)
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic [31:0] dsp_a,
  output logic [31:0] dsp_b,
  output logic        dsp_sign,
  output logic        dsp_ce,
  input  logic [63:0] dsp_p,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam logic [3:0] CNT_INIT = 4'(MULT_LATENCY - 1);

  logic [1:0]  state_q;
  logic [3:0]  cnt_q;
  logic [63:0] prod_p1;
  logic [63:0] hilo_nxt;
  logic        accept;
  logic        launch;

  assign req_ready = (state_q == ST_IDLE) & ~flush & ~reset;
  assign accept    = req_valid & req_ready;
  assign busy      = (state_q != ST_IDLE);
  assign dsp_ce    = (state_q == ST_MUL) & ~flush;

  // Ops that occupy the array; anything else accepted in IDLE completes without leaving IDLE.
  always_comb begin
    launch = 1'b0;
    case (req_op)
      OP_MULT, OP_MULTU: launch = 1'b1;
`ifdef MULT_MADDSUB_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: launch = 1'b1;
`endif
      default: launch = 1'b0;
    endcase
  end

`ifdef MULT_MADDSUB_EN
  logic [2:0] op_q;
  logic [1:0] acc_mode;

  assign acc_mode = op_acc_mode(op_q);

  hilo_accum u_accum (
    .mode   (acc_mode),
    .hilo   ({hi, lo}),
    .prod   (prod_p1),
    .result (hilo_nxt)
  );
`else
  assign hilo_nxt = prod_p1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      dsp_a    <= 32'd0;
      dsp_b    <= 32'd0;
      dsp_sign <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
`ifdef MULT_MADDSUB_EN
      op_q     <= OP_MULT;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (launch) begin
              dsp_a    <= req_a;
              dsp_b    <= req_b;
              dsp_sign <= op_is_signed(req_op);
              cnt_q    <= CNT_INIT;
              state_q  <= ST_MUL;
`ifdef MULT_MADDSUB_EN
              op_q     <= req_op;
`endif
            end else if (req_op == OP_MTHI) begin
              hi <= req_a;
            end else if (req_op == OP_MTLO) begin
              lo <= req_a;
            end
          end
        end
        ST_MUL: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == 4'd0) begin
            state_q <= ST_ACC;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ACC: begin
          if (!flush) begin
            hi <= hilo_nxt[63:32];
            lo <= hilo_nxt[31:0];
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---- product capture: dsp_p is valid in the last MUL cycle ----
  always_ff @(posedge clock) begin
    if ((state_q == ST_MUL) && (cnt_q == 4'd0) && !flush) begin
      prod_p1 <= dsp_p;
    end
  end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl with a clock-enabled pipeline standing in for the DSP array.
module tb_mult_hilo_ctrl;
  import mult_pkg::*;

  localparam int L = 4;

`ifdef MULT_MADDSUB_EN
  localparam bit MS = 1'b1;
`else
  localparam bit MS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic [31:0] dsp_a;
  logic [31:0] dsp_b;
  logic        dsp_sign;
  logic        dsp_ce;
  logic [63:0] dsp_p;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mult_hilo_ctrl #(.MULT_LATENCY(L)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .dsp_a     (dsp_a),
    .dsp_b     (dsp_b),
    .dsp_sign  (dsp_sign),
    .dsp_ce    (dsp_ce),
    .dsp_p     (dsp_p),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy)
  );

  // Array stand-in: product enters on the first enabled edge and emerges L-1 enabled edges later.
  function automatic logic [63:0] array_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{s & a[31]}}, a};
    sb = {{32{s & b[31]}}, b};
    return sa * sb;
  endfunction

  logic [63:0] pipe [0:L-2];
  always @(posedge clock) begin
    if (dsp_ce) begin
      pipe[0] <= array_mul(dsp_a, dsp_b, dsp_sign);
      for (int i = 1; i < L - 1; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign dsp_p = pipe[L-2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int busy_cyc, output int ce_cyc, output logic sgn);
    int w;
    w = 0;
    busy_cyc = 0;
    ce_cyc = 0;
    @(negedge clock);
    while (!req_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL issue_wait: got req_ready=0 want 1 within 20 cycles");
    end
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    sgn = dsp_sign;
    while (busy && busy_cyc < 40) begin
      busy_cyc++;
      if (dsp_ce) ce_cyc++;
      @(posedge clock);
      #1;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;
    logic        sgn;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, cc, n;
    logic sg;
    logic [31:0] hi_prev, lo_prev;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 1'b1};
    vecs[2]  = '{OP_MTHI,  32'h00000000, 32'h0,        32'h00000000, 32'hFFFFFFFA, 0, 1'b0};
    vecs[3]  = '{OP_MTLO,  32'hFFFFFFFF, 32'h0,        32'h00000000, 32'hFFFFFFFF, 0, 1'b0};
    vecs[4]  = MS ? '{OP_MADDU, 32'h1, 32'h1, 32'h00000001, 32'h00000000, 5, 1'b0}
                  : '{OP_MADDU, 32'h1, 32'h1, 32'h00000000, 32'hFFFFFFFF, 0, 1'b0};
    vecs[5]  = MS ? '{OP_MTHI, 32'h0, 32'h0, 32'h00000000, 32'h00000000, 0, 1'b0}
                  : '{OP_MTHI, 32'h0, 32'h0, 32'h00000000, 32'hFFFFFFFF, 0, 1'b0};
    vecs[6]  = '{OP_MTLO,  32'h00000000, 32'h0,        32'h00000000, 32'h00000000, 0, 1'b0};
    vecs[7]  = MS ? '{OP_MSUB, 32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b1}
                  : '{OP_MSUB, 32'h1, 32'h1, 32'h00000000, 32'h00000000, 0, 1'b0};
    vecs[8]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5, 1'b1};
    vecs[9]  = '{OP_MULTU, 32'h00000007, 32'hFFFFFFFD, 32'h00000006, 32'hFFFFFFEB, 5, 1'b0};
    vecs[10] = MS ? '{OP_MADD, 32'hFFFFFFFF, 32'h2, 32'h00000006, 32'hFFFFFFE9, 5, 1'b1}
                  : '{OP_MADD, 32'hFFFFFFFF, 32'h2, 32'h00000006, 32'hFFFFFFEB, 0, 1'b0};
    vecs[11] = MS ? '{OP_MSUBU, 32'h00010000, 32'h00010000, 32'h00000005, 32'hFFFFFFE9, 5, 1'b0}
                  : '{OP_MSUBU, 32'h00010000, 32'h00010000, 32'h00000006, 32'hFFFFFFEB, 0, 1'b0};

    reset = 1'b1;
    req_valid = 1'b0;
    req_op = OP_MULT;
    req_a = 32'h0;
    req_b = 32'h0;
    flush = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ce", 64'(dsp_ce), 64'd0);
    chk("rst_dsp_a", 64'(dsp_a), 64'd0);
    chk("rst_sign", 64'(dsp_sign), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, bc, cc, sg);
      chk($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
      chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'(vecs[i].busy));
      if (vecs[i].busy > 0) begin
        chk($sformatf("v%0d_ce_cycles", i), 64'(cc), 64'(L));
        chk($sformatf("v%0d_sign", i), 64'(sg), 64'(vecs[i].sgn));
      end
    end

    // Flush in the second MUL cycle leaves HI/LO alone
    hi_prev = vecs[11].hi;
    lo_prev = vecs[11].lo;
    @(negedge clock);
    req_valid = 1'b1;
    req_op = OP_MULT;
    req_a = 32'd5;
    req_b = 32'd5;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    flush = 1'b1;
    #1;
    chk("flush_ce", 64'(dsp_ce), 64'd0);
    chk("flush_ready", 64'(req_ready), 64'd0);
    @(posedge clock);
    #1;
    flush = 1'b0;
    #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_ready_after", 64'(req_ready), 64'd1);
    chk("flush_hi", 64'(hi), 64'(hi_prev));
    chk("flush_lo", 64'(lo), 64'(lo_prev));
    issue(OP_MULT, 32'd5, 32'd5, bc, cc, sg);
    chk("b2b_hi", 64'(hi), 64'h0);
    chk("b2b_lo", 64'(lo), 64'h19);
    chk("b2b_busy_cycles", 64'(bc), 64'd5);

    // Request coinciding with flush is refused
    @(negedge clock);
    flush = 1'b1;
    req_valid = 1'b1;
    req_op = OP_MTHI;
    req_a = 32'hCAFEF00D;
    #1;
    chk("flushreq_ready", 64'(req_ready), 64'd0);
    @(posedge clock);
    #1;
    flush = 1'b0;
    req_valid = 1'b0;
    chk("flushreq_hi", 64'(hi), 64'h0);
    chk("flushreq_busy", 64'(busy), 64'd0);

    // Request held while busy is ignored, then taken once IDLE
    @(negedge clock);
    req_valid = 1'b1;
    req_op = OP_MULTU;
    req_a = 32'd2;
    req_b = 32'd3;
    @(posedge clock);
    #1;
    req_op = OP_MTHI;
    req_a = 32'hDEADBEEF;
    chk("held_ready_busy", 64'(req_ready), 64'd0);
    n = 0;
    while (busy && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("held_edges", 64'(n), 64'd5);
    chk("held_hi_mid", 64'(hi), 64'h0);
    chk("held_lo_mid", 64'(lo), 64'h6);
    chk("held_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    chk("held_hi", 64'(hi), 64'hDEADBEEF);
    chk("held_lo", 64'(lo), 64'h6);

    // Reset while in ACC
    @(negedge clock);
    req_valid = 1'b1;
    req_op = OP_MULT;
    req_a = 32'd5;
    req_b = 32'd5;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    chk("acc_busy", 64'(busy), 64'd1);
    chk("acc_ce", 64'(dsp_ce), 64'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rstacc_hi", 64'(hi), 64'h0);
    chk("rstacc_lo", 64'(lo), 64'h0);
    chk("rstacc_busy", 64'(busy), 64'd0);
    chk("rstacc_ce", 64'(dsp_ce), 64'd0);
    chk("rstacc_ready", 64'(req_ready), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
